// File: rtl/rob_pkg.sv
// Shared widths, drain FSM encoding and store-queue entry layout for the ROB commit unit.
package rob_pkg;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 48;
  localparam int REG_W   = 5;
  localparam int ENTRY_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/rob_store_queue.sv
// In-order circular store queue; exposes the head and the entry behind it so the
// drain side can issue back-to-back requests.
module rob_store_queue #(
  parameter int ENTRY_BITS = 112,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_BITS  = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [ENTRY_BITS-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_BITS-1:0]   o_count,
  output logic [ENTRY_BITS-1:0] o_head,
  output logic [ENTRY_BITS-1:0] o_next_head
);

  logic [ENTRY_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_BITS-1:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CNT_BITS'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_next_head = r_mem[r_rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/rob_commit_unit.sv
// Retires ROB commits: register commits go to the RF write port, stores queue up and
// drain to data memory over req/ack. Handshake: a store moves when mem_req && mem_ack at a rising edge.
module rob_commit_unit #(
  parameter int DATA_W   = rob_pkg::DATA_W,
  parameter int ADDR_W   = rob_pkg::ADDR_W,
  parameter int REG_W    = rob_pkg::REG_W,
  parameter int SQ_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_ready_reg,
  input  logic                         commit_ready_mem,
  input  logic [DATA_W-1:0]            Data,
  input  logic [REG_W-1:0]             Destination_in,
  input  logic [ADDR_W-1:0]            Address_in,
  input  logic [rob_pkg::ENTRY_W-1:0]  Entry_num,
  output logic                         commit_stall,
  output logic                         rf_we,
  output logic [REG_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  output logic                         retire_valid,
  output logic [rob_pkg::ENTRY_W-1:0]  retire_entry,
  output logic [CNT_W-1:0]             retire_count,
  output logic                         protocol_err,
  output logic                         drained,
  output logic                         dbg_state
);

  import rob_pkg::*;

  localparam int PTR_W    = $clog2(SQ_DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam int EW       = ADDR_W + DATA_W;

  logic [CNT_BITS-1:0] w_sq_count;
  logic                w_sq_full;
  logic                w_sq_empty;
  logic [EW-1:0]       w_head;
  logic [EW-1:0]       w_next_head;
  logic                w_accept_reg;
  logic                w_accept_mem;
  logic                w_accept;
  logic                w_err_now;
  logic                w_more;
  logic                w_pop;
  logic                w_load;
  logic [EW-1:0]       w_load_data;
  drain_state_t        r_state;
  drain_state_t        w_next_state;

  logic [REG_W-1:0]    r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_retire_valid;
  logic [ENTRY_W-1:0]  r_retire_entry;
  logic [CNT_W-1:0]    r_retire_count;
  logic                r_protocol_err;

  assign commit_stall = w_sq_full;

  // A register commit wins when both strobes arrive together.
  assign w_accept_reg = commit_ready_reg & ~w_sq_full;
  assign w_accept_mem = commit_ready_mem & ~commit_ready_reg & ~w_sq_full;
  assign w_accept     = w_accept_reg | w_accept_mem;
  assign w_err_now    = ((commit_ready_reg | commit_ready_mem) & w_sq_full)
                      | (commit_ready_reg & commit_ready_mem);

  rob_store_queue #(
    .ENTRY_BITS (EW),
    .DEPTH      (SQ_DEPTH)
  ) u_sq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_accept_mem),
    .i_push_data ({Address_in, Data}),
    .i_pop       (w_pop),
    .o_full      (w_sq_full),
    .o_empty     (w_sq_empty),
    .o_count     (w_sq_count),
    .o_head      (w_head),
    .o_next_head (w_next_head)
  );

  assign w_more = (w_sq_count > CNT_BITS'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // A store pushed on the same edge as the last pop is forwarded straight into the request.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_load_data  = w_head;
    case (r_state)
      S_IDLE: begin
        if (!w_sq_empty) begin
          w_next_state = S_REQ;
          w_load       = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_pop = 1'b1;
          if (w_more || w_accept_mem) begin
            w_load      = 1'b1;
            w_load_data = w_more ? w_next_head : {Address_in, Data};
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_retire_valid <= 1'b0;
      r_retire_entry <= '0;
      r_retire_count <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_load) {r_mem_addr, r_mem_wdata} <= w_load_data;
      r_rf_we <= w_accept_reg;
      if (w_accept_reg) begin
        r_rf_waddr <= Destination_in;
        r_rf_wdata <= Data;
      end
      r_retire_valid <= w_accept;
      if (w_accept) begin
        r_retire_entry <= Entry_num;
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
      if (w_err_now) r_protocol_err <= 1'b1;
    end
  end

  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign mem_req      = (r_state == S_REQ);
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign retire_valid = r_retire_valid;
  assign retire_entry = r_retire_entry;
  assign retire_count = r_retire_count;
  assign protocol_err = r_protocol_err;
  assign drained      = w_sq_empty && (r_state == S_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: RF writes, store drain order, back-pressure,
// illegal strobes and asynchronous reset.
module tb_rob_commit_unit;
  import rob_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                commit_ready_reg, commit_ready_mem;
  logic [DATA_W-1:0]   Data;
  logic [REG_W-1:0]    Destination_in;
  logic [ADDR_W-1:0]   Address_in;
  logic [ENTRY_W-1:0]  Entry_num;
  logic                commit_stall, rf_we, mem_req, mem_ack;
  logic [REG_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]   rf_wdata, mem_wdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                retire_valid, protocol_err, drained, dbg_state;
  logic [ENTRY_W-1:0]  retire_entry;
  logic [31:0]         retire_count;

  int checks   = 0;
  int failures = 0;
  sq_entry_t          exp_q[$];
  sq_entry_t          exp_e;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .rst(rst),
    .commit_ready_reg(commit_ready_reg), .commit_ready_mem(commit_ready_mem),
    .Data(Data), .Destination_in(Destination_in), .Address_in(Address_in),
    .Entry_num(Entry_num), .commit_stall(commit_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .retire_valid(retire_valid), .retire_entry(retire_entry), .retire_count(retire_count),
    .protocol_err(protocol_err), .drained(drained), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task drive_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                   input logic [ENTRY_W-1:0] e, input bit expect_queued);
    commit_ready_mem = 1'b1;
    Address_in       = a;
    Data             = d;
    Entry_num        = e;
    if (expect_queued) begin
      exp_e.addr = a;
      exp_e.data = d;
      exp_q.push_back(exp_e);
    end
  endtask

  task chk_head(input string tag);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=empty_model expected=entry", tag);
    end else begin
      exp_e = exp_q.pop_front();
      chk({tag, "_req"}, 64'(mem_req), 64'd1);
      chk({tag, "_addr"}, 64'(mem_addr), 64'(exp_e.addr));
      chk({tag, "_data"}, mem_wdata, exp_e.data);
    end
  endtask

  task do_reset;
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    commit_ready_reg = 0; commit_ready_mem = 0; mem_ack = 0;
    Data = '0; Destination_in = '0; Address_in = '0; Entry_num = '0;

    // Reset values
    #3;
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_retire_count", 64'(retire_count), 0);
    chk("rst_protocol_err", 64'(protocol_err), 0);
    chk("rst_drained", 64'(drained), 1);
    chk("rst_stall", 64'(commit_stall), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Register commit: one-cycle RF write
    commit_ready_reg = 1; Destination_in = 5'd7; Data = 64'hDEAD_BEEF; Entry_num = 3'd3;
    tick();
    commit_ready_reg = 0;
    chk("reg_we", 64'(rf_we), 1);
    chk("reg_waddr", 64'(rf_waddr), 7);
    chk("reg_wdata", rf_wdata, 64'hDEAD_BEEF);
    chk("reg_retire_valid", 64'(retire_valid), 1);
    chk("reg_retire_entry", 64'(retire_entry), 3);
    chk("reg_retire_count", 64'(retire_count), 1);
    tick();
    chk("reg_we_pulse", 64'(rf_we), 0);
    chk("reg_retire_valid_pulse", 64'(retire_valid), 0);

    // Single store with delayed ack
    drive_store(48'h1000, 64'h55, 3'd5, 1'b1);
    tick();
    commit_ready_mem = 0;
    chk("st1_req_lat", 64'(mem_req), 0);
    chk("st1_not_drained", 64'(drained), 0);
    chk("st1_entry", 64'(retire_entry), 5);
    tick();
    chk_head("st1_head");
    chk("st1_state", 64'(dbg_state), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st1_hold_req", 64'(mem_req), 1);
      chk("st1_hold_addr", 64'(mem_addr), 64'h1000);
      chk("st1_hold_data", mem_wdata, 64'h55);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("st1_req_drop", 64'(mem_req), 0);
    chk("st1_drained", 64'(drained), 1);
    chk("st1_count", 64'(retire_count), 2);

    // Fill the queue, stall, then drain back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_store(48'h2000 + 48'(i), 64'hA0 + 64'(i), 3'(i), 1'b1);
      tick();
    end
    chk("full_stall", 64'(commit_stall), 1);
    chk("full_err_clear", 64'(protocol_err), 0);
    chk("full_count", 64'(retire_count), 6);
    drive_store(48'h2004, 64'hA4, 3'd4, 1'b0);
    tick();
    commit_ready_mem = 0;
    chk("stalled_err", 64'(protocol_err), 1);
    chk("stalled_count", 64'(retire_count), 6);
    chk("stalled_valid", 64'(retire_valid), 0);
    chk("stalled_still_full", 64'(commit_stall), 1);
    chk_head("drain0");
    mem_ack = 1;
    tick();
    chk("drain_unstall", 64'(commit_stall), 0);
    chk_head("drain1");
    tick();
    chk_head("drain2");
    tick();
    chk_head("drain3");
    tick();
    mem_ack = 0;
    chk("drain_done_req", 64'(mem_req), 0);
    chk("drain_done_drained", 64'(drained), 1);
    chk("drain_model_empty", 64'(exp_q.size()), 0);
    tick();
    chk("err_sticky", 64'(protocol_err), 1);

    do_reset();
    chk("rst2_err", 64'(protocol_err), 0);
    chk("rst2_count", 64'(retire_count), 0);

    // Wrap-around: six stores with single-cycle acks
    for (int i = 0; i < 6; i++) begin
      drive_store(48'h3000 + 48'(i * 16), 64'h1_0000 + 64'(i * 3), 3'(i), 1'b1);
      tick();
      commit_ready_mem = 0;
      tick();
      chk_head("wrap_head");
      mem_ack = 1;
      tick();
      mem_ack = 0;
      chk("wrap_req_drop", 64'(mem_req), 0);
    end
    chk("wrap_count", 64'(retire_count), 6);
    chk("wrap_drained", 64'(drained), 1);

    // Simultaneous strobes: register only
    commit_ready_reg = 1; commit_ready_mem = 1;
    Destination_in = 5'd31; Data = 64'h1234; Address_in = 48'h4000; Entry_num = 3'd6;
    tick();
    commit_ready_reg = 0; commit_ready_mem = 0;
    chk("both_we", 64'(rf_we), 1);
    chk("both_waddr", 64'(rf_waddr), 31);
    chk("both_wdata", rf_wdata, 64'h1234);
    chk("both_err", 64'(protocol_err), 1);
    chk("both_drained", 64'(drained), 1);
    chk("both_count", 64'(retire_count), 7);
    tick();
    chk("both_no_req", 64'(mem_req), 0);
    chk("both_still_drained", 64'(drained), 1);

    // Async reset while a request is outstanding with two stores queued
    drive_store(48'h5000, 64'h77, 3'd1, 1'b1);
    tick();
    drive_store(48'h5001, 64'h78, 3'd2, 1'b1);
    tick();
    commit_ready_mem = 0;
    chk_head("pre_rst_head");
    chk("pre_rst_not_drained", 64'(drained), 0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("async_req_drop", 64'(mem_req), 0);
    chk("async_drained", 64'(drained), 1);
    chk("async_count", 64'(retire_count), 0);
    chk("async_err", 64'(protocol_err), 0);
    chk("async_addr", 64'(mem_addr), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_req", 64'(mem_req), 0);
      chk("post_rst_drained", 64'(drained), 1);
    end
    chk("post_rst_count", 64'(retire_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
